// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word fall-through byte FIFO for CPU loads.
// Define UART_RX_PARITY_EN for 8E1 frames and a sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               rxs_q, rxs_d;
    logic               rxs_prev_q, rxs_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_err_q, parity_err_d;
    logic               set_parity;
`endif
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               cnt_zero;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic               set_frame;

    assign cnt_zero = (cnt_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign pop      = rd_en && (count_q != '0);
    assign push     = push_req && (!full || pop);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        push_req     = 1'b0;
        set_frame    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        set_parity   = 1'b0;
`endif
        sync1_d      = uart_rx;
        rxs_d        = sync1_q;
        rxs_prev_d   = rxs_q;

        // Start only on a high-to-low transition so a held-low break cannot retrigger.
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = FULL_RELOAD;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = FULL_RELOAD;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bad_d = ^{shift_q, rxs_q};
                    cnt_d     = FULL_RELOAD;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    set_frame  = !rxs_q;
                    set_parity = par_bad_q;
                    push_req   = rxs_q && !par_bad_q;
`else
                    set_frame  = !rxs_q;
                    push_req   = rxs_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A set in the same cycle as clr_err wins.
        overrun_d    = (overrun_q && !clr_err) || (push_req && full && !pop);
        frame_err_d  = (frame_err_q && !clr_err) || set_frame;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !clr_err) || set_parity;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_data   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_empty  = (count_q == '0);
    assign rx_count  = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY = 2 + 5 + 100 + 1;
`else
    localparam int LATENCY = 2 + 5 + 90 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   fall_cyc = -1;
    logic prev_empty = 1'b1;
    logic [7:0] got;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .rd_data(rd_data),
        .rx_empty(rx_empty),
        .rx_count(rx_count),
        .overrun(overrun),
        .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle of the first empty-to-non-empty transition.
    always @(negedge clk) begin
        if (prev_empty === 1'b1 && rx_empty === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
        prev_empty = rx_empty;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame; optionally pops the FIFO head on the push cycle of this frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input bit pop_on_push, output logic [7:0] popped);
        popped = 8'h00;
        @(posedge clk); #1;
        start_cyc = cyc;
        uart_rx = 1'b0;
        repeat (10) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(posedge clk); #1;
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_bit;
        repeat (10) @(posedge clk); #1;
`else
        if (par_bit === 1'bx) uart_rx = 1'b1;
`endif
        uart_rx = stop_bit;
        if (pop_on_push) begin
            repeat (7) @(posedge clk); #1;
            rd_en  = 1'b1;
            popped = rd_data;
            @(posedge clk); #1;
            rd_en  = 1'b0;
            repeat (2) @(posedge clk); #1;
        end else begin
            repeat (10) @(posedge clk); #1;
        end
        uart_rx = 1'b1;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic pop(output logic [7:0] d);
        rd_en = 1'b1;
        d     = rd_data;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        chk("reset_empty", 32'(rx_empty), 32'd1);
        chk("reset_count", 32'(rx_count), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);

        // Basic receive with exact latency from line fall to rx_empty falling.
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, got);
        chk("a5_latency", 32'(fall_cyc - start_cyc), 32'(LATENCY));
        chk("a5_empty", 32'(rx_empty), 32'd0);
        chk("a5_count", 32'(rx_count), 32'd1);
        chk("a5_data", 32'(rd_data), 32'hA5);
        pop(got);
        chk("a5_pop", 32'(got), 32'hA5);
        chk("a5_after_empty", 32'(rx_empty), 32'd1);
        chk("a5_after_data", 32'(rd_data), 32'h00);

        pop(got);
        chk("pop_empty_data", 32'(got), 32'h00);
        chk("pop_empty_count", 32'(rx_count), 32'd0);

        // Short low glitch on idle line.
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("glitch_empty", 32'(rx_empty), 32'd1);
        chk("glitch_frame_err", 32'(frame_err), 32'd0);
        chk("glitch_overrun", 32'(overrun), 32'd0);

        // Stop bit low.
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, got);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_count", 32'(rx_count), 32'd0);
        pulse_clr();
        chk("ferr_clr", 32'(frame_err), 32'd0);
        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, got);
        chk("3c_count", 32'(rx_count), 32'd1);
        chk("3c_data", 32'(rd_data), 32'h3C);
        pop(got);
        chk("3c_pop", 32'(got), 32'h3C);

        // Overrun: five bytes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), 1'b0, got);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            pop(got);
            chk("ovr_pop", 32'(got), 32'(i));
        end
        chk("ovr_drained", 32'(rx_empty), 32'd1);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Full FIFO with a pop on the fifth push cycle.
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), 1'b1, ^8'(8'h10 + i), 1'b0, got);
        send_frame(8'h15, 1'b1, ^8'h15, 1'b1, got);
        chk("pp_popped", 32'(got), 32'h11);
        chk("pp_count", 32'(rx_count), 32'd4);
        chk("pp_overrun", 32'(overrun), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            pop(got);
            chk("pp_pop", 32'(got), 32'(8'h10 + i));
        end

        // Reset mid-frame flushes the FIFO and abandons the frame.
        send_frame(8'h81, 1'b1, ^8'h81, 1'b0, got);
        chk("pre_rst_count", 32'(rx_count), 32'd1);
        fork
            send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, got);
            begin
                repeat (35) @(posedge clk); #2;
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
            end
        join
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_empty", 32'(rx_empty), 32'd1);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, got);
        chk("post_rst_count", 32'(rx_count), 32'd1);
        chk("post_rst_data", 32'(rd_data), 32'h5A);
        pop(got);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, got);
        chk("par_ok_count", 32'(rx_count), 32'd1);
        chk("par_ok_data", 32'(rd_data), 32'h07);
        chk("par_ok_flag", 32'(parity_err), 32'd0);
        pop(got);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, got);
        chk("par_bad_flag", 32'(parity_err), 32'd1);
        chk("par_bad_count", 32'(rx_count), 32'd0);
        pulse_clr();
        chk("par_clr", 32'(parity_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Memory-mapped UART receiver: the inbound counterpart to the CPU's store-triggered UART transmitter. It deserializes 8N1 frames from the external `uart_rx` pin and buffers the bytes in a small FIFO. The core reads the bytes via a load from the UART receive address; the CPU's memory-access stage drives `rd_en` on that load and muxes `rd_data` into the load path.

## Interface
- `CLK_HZ`, default 27000000: system clock frequency.
- `BAUD`, default 115200: line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division), must be ≥ 4.
- `FIFO_DEPTH`, default 16: power of two, ≥ 2.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `uart_rx`, in, 1: asynchronous serial input; idles high.
- `rd_en`, in, 1: pop request for the FIFO head.
- `rd_data`, out, 8: FIFO head (first-word fall-through); 8'h00 when empty.
- `rx_empty`, out, 1: FIFO empty.
- `rx_count`, out, $clog2(FIFO_DEPTH)+1: occupancy.
- `overrun`, out, 1: sticky; set when a good byte arrives while the FIFO is full.
- `frame_err`, out, 1: sticky; set when the stop bit is sampled low.
- `clr_err`, in, 1: clears `overrun`, `frame_err` (and `parity_err` when configured).

## Operation
- **Input sync:** `uart_rx` passes through a 2-flop synchronizer. The synchronizer resets to 1. All FSM decisions use the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
- **IDLE:** on `rxs==0`, load the bit counter with `CLKS_PER_BIT/2 - 1`, go to START.
- **START:** at counter 0, sample `rxs`.
  - 1: glitch; return to IDLE, no flags.
  - 0: reload `CLKS_PER_BIT - 1`, bit index = 0, go to DATA.
- **DATA:** at each counter expiry, shift `rxs` into bit[index] (LSB first) and reload. After index 7, go to STOP (or PARITY when configured).
- **STOP:** at expiry, sample `rxs`.
  - 1: push the byte (or set `overrun` and drop it if the FIFO is full and not popped this cycle).
  - 0: set `frame_err`, discard the byte.
  - Either way return to IDLE, which waits for the next `rxs==0`. A break (line held low) re-enters START only after the line returns high and falls again.
- **FIFO:** circular buffer with wrapping read/write pointers and a separate occupancy count.
  - Pop when `rd_en && !rx_empty`; `rd_en` on empty is ignored, no state change.
  - Simultaneous push and pop when full: both happen, count unchanged, no overrun.
- **Error flags:** a set and `clr_err` in the same cycle: the set wins.

## Timing
- **Reset values:** FSM IDLE, pointers 0, `rx_count` 0, `rx_empty` 1, `rd_data` 8'h00, all flags 0. Reset mid-frame abandons the frame and flushes the FIFO.
- **Sampling:** each bit is sampled ≈ mid-bit, `CLKS_PER_BIT/2` cycles after the synchronized falling edge plus n·`CLKS_PER_BIT`.
- **Push latency:** push is registered on the stop-sample cycle. `rx_empty` falls and `rd_data` is valid the next cycle.
- **Pop:** at the clock edge with `rd_en`; `rd_data` shows the next entry the following cycle. `rd_data` must be captured in the same cycle `rd_en` is asserted. In the multi-cycle CPU, `rd_en` is one cycle wide per load (MA stage only).
- **Receive latency:** line fall to byte available is 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles (add `CLKS_PER_BIT` with parity).

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Frame is 8E1; the PARITY state samples one extra bit between data and stop.
  - Even-parity mismatch sets sticky output `parity_err` (1 bit, reset 0, cleared by `clr_err`) and discards the byte. The stop bit is still checked.
- **Undefined:** frame is 8N1; the `parity_err` port is absent.

## Test plan
- CLK_HZ=1000000, BAUD=100000 (10 clk/bit): send 0xA5 → `rx_empty` falls exactly 2+5+90+1 cycles after line fall; `rd_data`=0xA5; `rd_en` pulse → `rx_empty`=1, `rd_data`=0x00.
- 3-cycle low glitch on idle line → FSM returns to IDLE, `rx_empty` stays 1, no flags.
- Send 0x3C with stop bit low → `frame_err`=1, FIFO unchanged; `clr_err` → 0; next 0x3C received normally.
- FIFO_DEPTH=4: send 0x01..0x05 without reads → `rx_count`=4, `overrun`=1, pops return 0x01..0x04. Repeat with `rd_en` on the 5th push cycle → no overrun, count stays 4.
- Assert `rst` mid-data-bit, then send 0x5A → only 0x5A in the FIFO, `rx_count`=1.
- With `UART_RX_PARITY_EN`: 0x07 with parity=1 → accepted; parity=0 → `parity_err`=1, byte dropped.
